dm_responder: RTL and testbench

- Multi-cycle data-memory responder; the target end of the CPU's load/store interface.
- Accepts one word request at a time over a req/ready handshake and inserts a programmable number of wait states.
- Performs byte-enabled writes and word reads, and flags misaligned or out-of-range accesses.
- Lets the multi-cycle/pipelined CPU datapath be exercised against a memory that does not answer combinationally.

---
 rtl/dm_responder.sv | 164 ++++++++++++++++
 tb/tb_dm_responder.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_responder.sv
// =============================================================================
// Module   : dm_responder
// Summary  : Multi-cycle data-memory target with programmable wait states,
//            byte-enabled writes and fault flagging. DM_RESPONDER_LOG_EN
//            enables a commit log on the simulation console.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module dm_responder #(
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  input  logic [31:0] pc,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         C_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [3:0] C_WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic       C_ZERO_WAIT = (WAIT_CYCLES == 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [C_DEPTH-1:0][31:0] mem_q;

  logic                  w_commit;
  logic                  w_fault;
  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [31:0]           w_old_word;
  logic [31:0]           w_merged;

  // The *_d transaction fields already select the live inputs in IDLE, so the
  // zero-wait case commits from the same view as the registered case.
  assign w_idx      = addr_d[DEPTH_LOG2+1:2];
  assign w_fault    = (addr_d[1:0] != 2'b00) || ((addr_d >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_commit   = ((state_q == S_IDLE) && req && C_ZERO_WAIT) ||
                      ((state_q == S_WAIT) && (cnt_q == 4'd1));
  assign w_old_word = mem_q[w_idx];
  assign w_mem_we   = w_commit && we_d && !w_fault;

  generate
    for (genvar i = 0; i < 4; i++) begin : g_byte_merge
      assign w_merged[8*i +: 8] = be_d[i] ? wdata_d[8*i +: 8] : w_old_word[8*i +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    pc_d    = pc_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          be_d    = be;
          pc_d    = pc;
          if (C_ZERO_WAIT) begin
            state_d = S_RESP;
            cnt_d   = 4'd0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = C_WAIT_INIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (w_commit) begin
      if (w_fault) begin
        rdata_d = 32'd0;
        err_d   = 1'b1;
      end else if (we_d) begin
        rdata_d = 32'd0;
        err_d   = 1'b0;
      end else begin
        rdata_d = w_old_word;
        err_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      pc_q    <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      pc_q    <= pc_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (w_mem_we) begin
        mem_q[w_idx] <= w_merged;
      end
`ifdef DM_RESPONDER_LOG_EN
      if (w_commit && w_fault) begin
        $display("%d@%h: DM fault %h", $time, pc_d, addr_d);
      end else if (w_mem_we) begin
        $display("%d@%h: *%h <= %h", $time, pc_d, {addr_d[31:2], 2'b00}, w_merged);
      end
`else
`endif
    end
  end

  assign ready = (state_q == S_RESP);
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_responder.sv
// =============================================================================
// Module   : tb_dm_responder
// Summary  : Scoreboard bench for dm_responder with a 2-wait and a 0-wait
//            instance sharing clock, reset and request payload.
// Revision : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dm_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, req2, req0, we;
  logic [31:0] addr, wdata, pc;
  logic [3:0]  be;
  logic        ready2, err2, ready0, err0;
  logic [31:0] rdata2, rdata0;

  dm_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .req(req2), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .pc(pc), .ready(ready2), .rdata(rdata2), .err(err2)
  );

  dm_responder #(.DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we), .addr(addr), .wdata(wdata),
    .be(be), .pc(pc), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  typedef struct packed {
    bit          sel;   // 0: 2-wait instance, 1: 0-wait instance
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } op_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model[int];
  int          checks   = 0;
  int          failures = 0;

  function automatic logic [31:0] model_rd(input int key);
    return model.exists(key) ? model[key] : 32'd0;
  endfunction

  task automatic scribble(input bit sel);
    we    = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
    be    = 4'($urandom);
    pc    = $urandom;
    if (sel) req0 = 1'($urandom);
    else     req2 = 1'($urandom);
  endtask

  // Drives one request, records its expectation, and returns what the DUT did.
  task automatic issue(input bit sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output int lat, output logic [31:0] rd, output logic er,
                       output bit one_cycle);
    logic        fault;
    int          key;
    logic [31:0] old, m;
    exp_t        e;
    fault   = (a[1:0] != 2'b00) || (a[31:14] != 18'd0);
    key     = (sel ? 4096 : 0) + int'(a[13:2]);
    old     = model_rd(key);
    e.lat   = sel ? 0 : 2;
    e.err   = fault;
    e.rdata = (fault || w) ? 32'd0 : old;
    if (!fault && w) begin
      m = old;
      for (int i = 0; i < 4; i++) if (b[i]) m[8*i +: 8] = d[8*i +: 8];
      model[key] = m;
    end
    sb.push_back(e);

    @(negedge clk);
    we = w; addr = a; wdata = d; be = b; pc = $urandom;
    if (sel) req0 = 1'b1;
    else     req2 = 1'b1;
    @(posedge clk); #1;
    req0 = 1'b0; req2 = 1'b0;
    lat = 0;
    while (((sel ? ready0 : ready2) !== 1'b1) && lat < 20) begin
      @(negedge clk); scribble(sel);
      @(posedge clk); #1;
      lat++;
    end
    rd = sel ? rdata0 : rdata2;
    er = sel ? err0 : err2;
    @(negedge clk); scribble(sel);
    @(posedge clk); #1;
    one_cycle = ((sel ? ready0 : ready2) === 1'b0);
    req0 = 1'b0; req2 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; req2 = 1'b1; req0 = 1'b1; we = 1'b1;
    addr = 32'h10; wdata = 32'hFFFF_FFFF; be = 4'hF; pc = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({ready2, err2, rdata2, ready0, err0, rdata0} !== 66'd0) begin
        failures++;
        $display("FAIL reset_hold[%0d]: got ready2=%b err2=%b rdata2=%h ready0=%b err0=%b rdata0=%h, want all zero",
                 i, ready2, err2, rdata2, ready0, err0, rdata0);
      end
    end
    @(negedge clk);
    req2 = 1'b0; req0 = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ready2 !== 1'b0 || ready0 !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ready2=%b ready0=%b, want 0 0", ready2, ready0);
    end
    model.delete();
    sb.delete();
  endtask

  task automatic test_read_after_reset;
    int lat; logic [31:0] rd; logic er; bit oc; exp_t e;
    issue(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, er, oc);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err || !oc) begin
      failures++;
      $display("FAIL read_after_reset: got lat=%0d rdata=%h err=%b single_ready=%0b, want lat=%0d rdata=%h err=%b single_ready=1",
               lat, rd, er, oc, e.lat, e.rdata, e.err);
    end
  endtask

  task automatic test_write_readback;
    op_t ops[6]; int lat; logic [31:0] rd; logic er; bit oc; exp_t e;
    ops = '{'{1'b0, 1'b1, 32'h20, 32'h1234_5678, 4'hF},
            '{1'b0, 1'b0, 32'h20, 32'h0,         4'h0},
            '{1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101},
            '{1'b0, 1'b0, 32'h20, 32'h0,         4'h0},
            '{1'b0, 1'b1, 32'h20, 32'h0,         4'b0000},
            '{1'b0, 1'b0, 32'h20, 32'h0,         4'h0}};
    foreach (ops[i]) begin
      issue(ops[i].sel, ops[i].w, ops[i].a, ops[i].d, ops[i].b, lat, rd, er, oc);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err || !oc) begin
        failures++;
        $display("FAIL write_readback[%0d]: got lat=%0d rdata=%h err=%b single_ready=%0b, want lat=%0d rdata=%h err=%b single_ready=1",
                 i, lat, rd, er, oc, e.lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_faults;
    op_t ops[6]; int lat; logic [31:0] rd; logic er; bit oc; exp_t e;
    ops = '{'{1'b0, 1'b0, 32'h0000_0022, 32'h0,         4'h0},
            '{1'b0, 1'b1, 32'h0000_4000, 32'hDEAD_BEEF, 4'hF},
            '{1'b0, 1'b1, 32'h0000_0021, 32'hDEAD_BEEF, 4'hF},
            '{1'b0, 1'b0, 32'h8000_0020, 32'h0,         4'h0},
            '{1'b0, 1'b0, 32'h0000_0020, 32'h0,         4'h0},
            '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'h0}};
    foreach (ops[i]) begin
      issue(ops[i].sel, ops[i].w, ops[i].a, ops[i].d, ops[i].b, lat, rd, er, oc);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err || !oc) begin
        failures++;
        $display("FAIL faults[%0d]: got lat=%0d rdata=%h err=%b single_ready=%0b, want lat=%0d rdata=%h err=%b single_ready=1",
                 i, lat, rd, er, oc, e.lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset_mid;
    op_t ops[3]; int lat; logic [31:0] rd; logic er; bit oc; exp_t e;
    int pulses;
    @(negedge clk);
    we = 1'b1; addr = 32'h30; wdata = 32'hFFFF_FFFF; be = 4'hF; req2 = 1'b1;
    @(posedge clk); #1;
    req2 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (ready2 === 1'b1 || err2 === 1'b1) pulses++;
      if (i == 1) begin
        @(negedge clk);
        reset = 1'b1;
      end
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL reset_mid_no_ready: got %0d ready/err cycles, want 0", pulses);
    end
    model.delete();
    ops = '{'{1'b0, 1'b0, 32'h30, 32'h0, 4'h0},
            '{1'b0, 1'b0, 32'h20, 32'h0, 4'h0},
            '{1'b1, 1'b0, 32'h30, 32'h0, 4'h0}};
    foreach (ops[i]) begin
      issue(ops[i].sel, ops[i].w, ops[i].a, ops[i].d, ops[i].b, lat, rd, er, oc);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err || !oc) begin
        failures++;
        $display("FAIL reset_mid[%0d]: got lat=%0d rdata=%h err=%b single_ready=%0b, want lat=%0d rdata=%h err=%b single_ready=1",
                 i, lat, rd, er, oc, e.lat, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_back_to_back;
    op_t ops[2]; int lat; logic [31:0] rd; logic er; bit oc; exp_t e;
    logic exp_rdy;
    issue(1'b1, 1'b1, 32'h44, 32'hCAFE_F00D, 4'hF, lat, rd, er, oc);
    e = sb.pop_front();
    checks++;
    if (lat !== e.lat || rd !== e.rdata || er !== e.err || !oc) begin
      failures++;
      $display("FAIL b2b_setup: got lat=%0d rdata=%h err=%b single_ready=%0b, want lat=%0d rdata=%h err=%b single_ready=1",
               lat, rd, er, oc, e.lat, e.rdata, e.err);
    end
    // req stays high; odd cycles carry a clobbering write that must be ignored.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0 = 1'b1; addr = 32'h44; pc = $urandom;
      if (i % 2 == 0) begin
        we = 1'b0; wdata = 32'h0; be = 4'h0;
        sb.push_back('{rdata: 32'hCAFE_F00D, err: 1'b0, lat: 0});
      end else begin
        we = 1'b1; wdata = 32'hFFFF_FFFF; be = 4'hF;
      end
      exp_rdy = (i % 2 == 0);
      @(posedge clk); #1;
      checks++;
      if (ready0 !== exp_rdy) begin
        failures++;
        $display("FAIL b2b_ready[%0d]: got ready=%b, want %b", i, ready0, exp_rdy);
      end
      if (ready0 === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra[%0d]: got unexpected ready, want no response", i);
        end else begin
          e = sb.pop_front();
          if (rdata0 !== e.rdata || err0 !== e.err) begin
            failures++;
            $display("FAIL b2b_data[%0d]: got rdata=%h err=%b, want rdata=%h err=%b",
                     i, rdata0, err0, e.rdata, e.err);
          end
        end
      end
    end
    @(negedge clk);
    req0 = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL b2b_pending: got %0d unanswered requests, want 0", sb.size());
      sb.delete();
    end
    ops = '{'{1'b1, 1'b0, 32'h44, 32'h0, 4'h0},
            '{1'b0, 1'b0, 32'h44, 32'h0, 4'h0}};
    foreach (ops[i]) begin
      issue(ops[i].sel, ops[i].w, ops[i].a, ops[i].d, ops[i].b, lat, rd, er, oc);
      e = sb.pop_front();
      checks++;
      if (lat !== e.lat || rd !== e.rdata || er !== e.err || !oc) begin
        failures++;
        $display("FAIL b2b_readback[%0d]: got lat=%0d rdata=%h err=%b single_ready=%0b, want lat=%0d rdata=%h err=%b single_ready=1",
                 i, lat, rd, er, oc, e.lat, e.rdata, e.err);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_write_readback();
    test_faults();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
